// File: rtl/tile_conv_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tile_conv_accumulator
// Description : Multi-channel 3x3 valid-correlation over 6x6 tiles, accumulated
//               into one 4x4 output tile with optional ReLU and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_conv_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CH     = 16,
    parameter int SATURATE   = 1,
    localparam int CH_W      = $clog2(MAX_CH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CH_W-1:0]       num_ch,
    input  logic                  relu_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] kernel_in  [3][3],
    input  logic [DATA_WIDTH-1:0] tile_in    [6][6],
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [DATA_WIDTH-1:0] result_out [4][4],
    output logic                  busy
);

    localparam int c_ACC_W  = 2 * DATA_WIDTH + $clog2(9 * MAX_CH);
    localparam int c_PROD_W = 2 * DATA_WIDTH;
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX =
        {{(c_ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN =
        {{(c_ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_COMPUTE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [CH_W-1:0]             r_num_ch;
    logic [CH_W-1:0]             r_ch_done;
    logic                        r_relu;
    logic [3:0]                  r_idx;
    logic [DATA_WIDTH-1:0]       r_kernel [3][3];
    logic [DATA_WIDTH-1:0]       r_tile   [6][6];
    logic signed [c_ACC_W-1:0]   r_acc    [4][4];
    logic [DATA_WIDTH-1:0]       r_result [4][4];
    logic                        r_result_valid;

    logic [1:0]                  w_row;
    logic [1:0]                  w_col;
    logic signed [c_PROD_W-1:0]  w_prod [3][3];
    logic signed [c_ACC_W-1:0]   w_dot;
    logic [DATA_WIDTH-1:0]       w_post [4][4];
    logic [CH_W-1:0]             w_num_ch_eff;
    logic [CH_W-1:0]             w_ch_next;
    logic                        w_last_ch;

    // ReLU is applied before the range clamp so a clamped negative never leaks through.
    function automatic logic [DATA_WIDTH-1:0] f_post(
        input logic signed [c_ACC_W-1:0] a,
        input logic                      relu
    );
        logic signed [c_ACC_W-1:0] v;
        v = (relu && a[c_ACC_W-1]) ? '0 : a;
        if (SATURATE != 0) begin
            if (v > c_SAT_MAX) begin
                v = c_SAT_MAX;
            end else if (v < c_SAT_MIN) begin
                v = c_SAT_MIN;
            end
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    assign w_row        = r_idx[3:2];
    assign w_col        = r_idx[1:0];
    assign w_ch_next    = r_ch_done + CH_W'(1);
    assign w_last_ch    = (w_ch_next >= r_num_ch);
    assign w_num_ch_eff = (num_ch == '0)            ? CH_W'(1)      :
                          (num_ch > CH_W'(MAX_CH))  ? CH_W'(MAX_CH) : num_ch;

    assign in_ready     = (r_state == S_WAIT_IN);
    assign busy         = (r_state != S_IDLE);
    assign result_valid = r_result_valid;
    assign result_out   = r_result;

    // Nine parallel multipliers over the 3x3 window anchored at the current pixel.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_prod[i][j] =
                    c_PROD_W'($signed(r_tile[{1'b0, w_row} + 3'(i)][{1'b0, w_col} + 3'(j)])) *
                    c_PROD_W'($signed(r_kernel[i][j]));
            end
        end
    end

    always_comb begin
        w_dot = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_dot = w_dot + c_ACC_W'(w_prod[i][j]);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_post[r][c] = f_post(r_acc[r][c], r_relu);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (r_idx == 4'd15) begin
                    w_state_nxt = w_last_ch ? S_OUTPUT : S_WAIT_IN;
                end
            end
            S_OUTPUT: begin
                if (r_result_valid && result_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_ch       <= '0;
            r_ch_done      <= '0;
            r_relu         <= 1'b0;
            r_idx          <= '0;
            r_result_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_kernel[i][j] <= '0;
                end
            end
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    r_tile[i][j] <= '0;
                end
            end
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    r_acc[r][c]    <= '0;
                    r_result[r][c] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_ch  <= w_num_ch_eff;
                        r_relu    <= relu_en;
                        r_ch_done <= '0;
                        r_idx     <= '0;
                        for (int r = 0; r < 4; r++) begin
                            for (int c = 0; c < 4; c++) begin
                                r_acc[r][c] <= '0;
                            end
                        end
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        r_kernel <= kernel_in;
                        r_tile   <= tile_in;
                        r_idx    <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_acc[w_row][w_col] <= r_acc[w_row][w_col] + w_dot;
                    r_idx               <= r_idx + 4'd1;
                    if (r_idx == 4'd15) begin
                        r_ch_done <= w_ch_next;
                    end
                end
                S_OUTPUT: begin
                    // First OUTPUT cycle captures the finished sums; the tile then holds until taken.
                    if (!r_result_valid) begin
                        r_result_valid <= 1'b1;
                        r_result       <= w_post;
                    end else if (result_ready) begin
                        r_result_valid <= 1'b0;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_conv_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_conv_accumulator
// Description : Scoreboard bench for tile_conv_accumulator (32-bit saturating
//               unit plus a 16-bit saturating/truncating pair).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_conv_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // 32-bit saturating instance
    logic        start = 1'b0;
    logic [4:0]  num_ch = '0;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] kernel_in [3][3];
    logic [31:0] tile_in   [6][6];
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic [31:0] result_out [4][4];
    logic        busy;

    // 16-bit instances sharing one stimulus
    logic        start16 = 1'b0;
    logic [4:0]  num16 = 5'd1;
    logic        relu16 = 1'b0;
    logic        valid16 = 1'b0;
    logic        rdy16_s, rdy16_t;
    logic [15:0] k16 [3][3];
    logic [15:0] t16 [6][6];
    logic        rv16_s, rv16_t;
    logic        rr16 = 1'b1;
    logic [15:0] r16_s [4][4];
    logic [15:0] r16_t [4][4];
    logic        busy16_s, busy16_t;

    logic [511:0] q_exp  [$];
    string        q_name [$];
    int           q16    [$];

    tile_conv_accumulator #(.DATA_WIDTH(32), .MAX_CH(16), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .num_ch(num_ch), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .kernel_in(kernel_in), .tile_in(tile_in),
        .result_valid(result_valid), .result_ready(result_ready), .result_out(result_out),
        .busy(busy)
    );

    tile_conv_accumulator #(.DATA_WIDTH(16), .MAX_CH(16), .SATURATE(1)) dut16_sat (
        .clk(clk), .rst(rst), .start(start16), .num_ch(num16), .relu_en(relu16),
        .in_valid(valid16), .in_ready(rdy16_s), .kernel_in(k16), .tile_in(t16),
        .result_valid(rv16_s), .result_ready(rr16), .result_out(r16_s), .busy(busy16_s)
    );

    tile_conv_accumulator #(.DATA_WIDTH(16), .MAX_CH(16), .SATURATE(0)) dut16_trunc (
        .clk(clk), .rst(rst), .start(start16), .num_ch(num16), .relu_en(relu16),
        .in_valid(valid16), .in_ready(rdy16_t), .kernel_in(k16), .tile_in(t16),
        .result_valid(rv16_t), .result_ready(rr16), .result_out(r16_t), .busy(busy16_t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard monitor for the 32-bit unit: one expected tile per result handshake.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=valid required=no result");
            end else begin
                logic [511:0] e;
                string        n;
                e = q_exp.pop_front();
                n = q_name.pop_front();
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        chk($sformatf("%s[%0d][%0d]", n, r, c), result_out[r][c], e[(r*4+c)*32 +: 32]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (rv16_s || rv16_t)) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result16 actual=valid required=no result");
            end else begin
                void'(q16.pop_front());
                chk("t3_both_valid", {30'd0, rv16_s, rv16_t}, 32'd3);
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        chk($sformatf("t3_sat[%0d][%0d]", r, c), {16'd0, r16_s[r][c]}, 32'd32767);
                        chk($sformatf("t3_trunc[%0d][%0d]", r, c), {16'd0, r16_t[r][c]}, 32'd9);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected tile for the ramp tile with kernel centre = sgn: out = sgn*(6r+c+8).
    task automatic push_ramp(input string nm, input int sgn, input bit relu);
        logic [511:0] e;
        int           v;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                v = sgn * (6 * r + c + 8);
                if (relu && v < 0) v = 0;
                e[(r*4+c)*32 +: 32] = v;
            end
        end
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic push_const(input string nm, input int v);
        logic [511:0] e;
        for (int k = 0; k < 16; k++) e[k*32 +: 32] = v;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic set_ramp(input int kc);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                kernel_in[i][j] = (i == 1 && j == 1) ? kc : 0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                tile_in[i][j] = i * 6 + j + 1;
    endtask

    task automatic set_ones();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                kernel_in[i][j] = 32'd1;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                tile_in[i][j] = 32'd1;
    endtask

    task automatic do_start(input int n, input logic relu);
        start   = 1'b1;
        num_ch  = 5'(n);
        relu_en = relu;
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input string nm, input bit hold);
        int w = 0;
        in_valid = 1'b1;
        while (!in_ready && w < 100) begin
            tick();
            w++;
        end
        chk({nm, "_in_ready_seen"}, {31'd0, in_ready}, 32'd1);
        tick();
        if (!hold) in_valid = 1'b0;
        chk({nm, "_compute_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({nm, "_compute_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_result(input string nm);
        int w = 0;
        while (!result_valid && w < 200) begin
            tick();
            w++;
        end
        chk({nm, "_latency"}, 32'(w), 32'd17);
    endtask

    task automatic close_job(input string nm);
        tick();
        chk({nm, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        set_ramp(1);
        for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) k16[i][j] = 16'd32767;
        for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) t16[i][j] = 16'd32767;
        repeat (3) tick();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_result_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_out00", result_out[0][0], 32'd0);
        chk("reset_out33", result_out[3][3], 32'd0);
        rst = 1'b0;
        tick();

        // T1: identity-centre kernel on ramp tile
        set_ramp(1);
        push_ramp("t1", 1, 1'b0);
        do_start(1, 1'b0);
        send("t1", 1'b0);
        wait_result("t1");
        close_job("t1");

        // T2: three all-ones channels, in_valid held high throughout
        set_ones();
        push_const("t2", 27);
        do_start(3, 1'b0);
        for (int ch = 0; ch < 3; ch++) send($sformatf("t2_ch%0d", ch), 1'b1);
        in_valid = 1'b0;
        wait_result("t2");
        close_job("t2");

        // T3: 16-bit saturate vs truncate
        q16.push_back(1);
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        chk("t3_in_ready", {30'd0, rdy16_s, rdy16_t}, 32'd3);
        valid16 = 1'b1;
        tick();
        valid16 = 1'b0;
        begin
            int w = 0;
            while (!rv16_s && w < 200) begin
                tick();
                w++;
            end
            chk("t3_latency", 32'(w), 32'd17);
        end
        tick();
        chk("t3_idle", {30'd0, busy16_s, busy16_t}, 32'd0);

        // T4: negative kernel, with and without ReLU
        set_ramp(-1);
        push_ramp("t4_norelu", -1, 1'b0);
        do_start(1, 1'b0);
        send("t4a", 1'b0);
        wait_result("t4a");
        close_job("t4a");
        push_ramp("t4_relu", -1, 1'b1);
        do_start(1, 1'b1);
        send("t4b", 1'b0);
        wait_result("t4b");
        close_job("t4b");

        // T5: num_ch=0 job with a stalled consumer and start pulses during the stall
        result_ready = 1'b0;
        set_ramp(-1);
        push_ramp("t5", -1, 1'b0);
        do_start(0, 1'b0);
        send("t5", 1'b0);
        wait_result("t5");
        for (int k = 0; k < 5; k++) begin
            start   = 1'b1;
            num_ch  = 5'd3;
            relu_en = 1'b1;
            tick();
            chk("t5_hold_valid", {31'd0, result_valid}, 32'd1);
            chk("t5_hold_busy", {31'd0, busy}, 32'd1);
            chk("t5_hold_out00", result_out[0][0], -32'sd8);
            chk("t5_hold_out33", result_out[3][3], -32'sd29);
        end
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_after_hs_valid", {31'd0, result_valid}, 32'd0);
        chk("t5_after_hs_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t5_start_ignored", {31'd0, busy}, 32'd0);

        // T6: reset during channel 2 of 3, then a clean job
        set_ramp(1);
        do_start(3, 1'b0);
        send("t6_ch0", 1'b0);
        send("t6_ch1", 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, result_valid}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_out00", result_out[0][0], 32'd0);
        chk("t6_rst_out33", result_out[3][3], 32'd0);
        tick();
        rst = 1'b0;
        tick();
        push_ramp("t6_fresh", 1, 1'b0);
        do_start(1, 1'b0);
        send("t6_fresh", 1'b0);
        wait_result("t6_fresh");
        close_job("t6_fresh");

        repeat (3) tick();
        chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);
        chk("scoreboard16_drained", 32'(q16.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
